// File: rtl/fetch_load_sequencer.sv
// fetch_load_sequencer: sequences the A/B/INSTR stream loads into the fetch unit, then starts the PE array and waits for it to finish
module fetch_load_sequencer #(
   parameter int BRAM_DEPTH       = 10,
   parameter int INSTR_BRAM_DEPTH = 11,
   parameter int TIMEOUT_W        = 16
) (
   input  logic                      S_AXIS_ACLK,
   input  logic                      S_AXIS_ARESET,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      err_clr,
   input  logic [31:0]               cfg_row_width,
   input  logic                      cfg_skip_b,
   input  logic                      S_AXIS_TVALID,
   input  logic                      S_AXIS_TLAST,
   input  logic                      pe_done,
   output logic [1:0]                bram_sel,
   output logic [31:0]               row_width,
   output logic                      pe_start,
   output logic                      seq_done,
   output logic                      busy,
   output logic                      error,
   output logic [1:0]                err_code,
   output logic                      stray_beat,
   output logic [INSTR_BRAM_DEPTH:0] beat_count
);
   localparam int BW = INSTR_BRAM_DEPTH + 1;
   localparam logic [BW-1:0] A_LIM = BW'(2 ** BRAM_DEPTH);
   localparam logic [BW-1:0] I_LIM = BW'(2 ** INSTR_BRAM_DEPTH);
   localparam logic [BW-1:0] BC_ONE = 1;
   localparam logic [TIMEOUT_W-1:0] WD_ONE = 1;
   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_I, FLUSH, RUN, ERR} state_t;
   state_t state, state_n;
   logic skip_b, skip_n, stray_n, pe_start_n, seq_done_n;
   logic [31:0] row_n;
   logic [1:0] code_n, sel_n;
   logic [BW-1:0] beat_n, bc_inc, lim;
   logic [TIMEOUT_W-1:0] wd, wd_n, wd_inc;
   assign bc_inc = beat_count + BC_ONE;
   assign wd_inc = wd + WD_ONE;
   assign lim = state == LOAD_I ? I_LIM : A_LIM;
   always_comb begin
      state_n    = state;
      beat_n     = beat_count;
      wd_n       = wd;
      row_n      = row_width;
      skip_n     = skip_b;
      code_n     = err_clr && !abort ? 2'b00 : err_code;
      stray_n    = stray_beat | (S_AXIS_TVALID & (state == IDLE || state == RUN || state == ERR));
      pe_start_n = 1'b0;
      seq_done_n = 1'b0;
      if (abort) begin
         state_n = IDLE;
         beat_n  = '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state_n = LOAD_A;
               row_n   = cfg_row_width;
               skip_n  = cfg_skip_b;
               stray_n = 1'b0;
               beat_n  = '0;
            end
            LOAD_A, LOAD_B, LOAD_I: if (S_AXIS_TVALID) begin
               if (S_AXIS_TLAST) begin
                  beat_n  = '0;
                  state_n = state == LOAD_A ? (skip_b ? LOAD_I : LOAD_B) : state == LOAD_B ? LOAD_I : FLUSH;
               end else begin
                  beat_n = &beat_count ? beat_count : bc_inc;
                  // a beat past the BRAM limit without TLAST would overrun the buffer
                  if (beat_count == lim) begin
                     state_n = ERR;
                     code_n  = 2'b01;
                  end
               end
            end
            FLUSH: begin
               state_n    = RUN;
               wd_n       = '0;
               pe_start_n = 1'b1;
            end
            RUN: if (pe_done) begin
               state_n    = IDLE;
               seq_done_n = 1'b1;
            end else begin
               wd_n = wd_inc;
               if (&wd_inc) begin
                  state_n = ERR;
                  code_n  = 2'b10;
               end
            end
            ERR: if (err_clr) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
      sel_n = state_n == LOAD_A ? 2'b00 : state_n == LOAD_B ? 2'b01 :
              (state_n == LOAD_I || state_n == FLUSH) ? 2'b10 : 2'b11;
   end
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         state      <= IDLE;
         bram_sel   <= 2'b11;
         row_width  <= '0;
         skip_b     <= 1'b0;
         pe_start   <= 1'b0;
         seq_done   <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
         err_code   <= 2'b00;
         stray_beat <= 1'b0;
         beat_count <= '0;
         wd         <= '0;
      end else begin
         state      <= state_n;
         bram_sel   <= sel_n;
         row_width  <= row_n;
         skip_b     <= skip_n;
         pe_start   <= pe_start_n;
         seq_done   <= seq_done_n;
         busy       <= state_n != IDLE;
         error      <= state_n == ERR;
         err_code   <= code_n;
         stray_beat <= stray_n;
         beat_count <= beat_n;
         wd         <= wd_n;
      end
   end
endmodule

// File: tb/tb_fetch_load_sequencer.sv
// tb_fetch_load_sequencer: randomized load/run scenarios checked against packet-level expectations
module tb_fetch_load_sequencer;
   logic clk = 0, rst = 1, start = 0, abort = 0, err_clr = 0, skip = 0;
   logic valid = 0, tlast = 0, pe_done = 0;
   logic [31:0] cfg_rw = 0, last_rw = 0;
   logic [1:0] bram_sel, err_code;
   logic [31:0] row_width;
   logic pe_start, seq_done, busy, error, stray_beat;
   logic [11:0] beat_count;
   int tests = 0, fails = 0;

   fetch_load_sequencer #(.BRAM_DEPTH(10), .INSTR_BRAM_DEPTH(11), .TIMEOUT_W(4)) dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start(start), .abort(abort), .err_clr(err_clr),
      .cfg_row_width(cfg_rw), .cfg_skip_b(skip), .S_AXIS_TVALID(valid), .S_AXIS_TLAST(tlast),
      .pe_done(pe_done), .bram_sel(bram_sel), .row_width(row_width), .pe_start(pe_start),
      .seq_done(seq_done), .busy(busy), .error(error), .err_code(err_code),
      .stray_beat(stray_beat), .beat_count(beat_count));

   always #5 clk = ~clk;
   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_packet(input int n, input bit last, input logic [1:0] sel);
      for (int i = 1; i <= n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            valid = 0;
            tlast = 1'($urandom_range(0, 1));
            tick();
         end
         valid = 1;
         tlast = last && i == n;
         tests++;
         if (bram_sel !== sel || beat_count !== 12'(i - 1)) begin
            fails++;
            $display("FAIL beat%0d: sel=%b cnt=%0d, expected sel=%b cnt=%0d", i, bram_sel, beat_count, sel, i - 1);
         end
         tick();
      end
      valid = 0;
      tlast = 0;
   endtask

   task automatic do_start(input logic [31:0] rw, input bit sk);
      cfg_rw = rw;
      skip = sk;
      start = 1;
      tick();
      start = 0;
      last_rw = rw;
      tests++;
      if ({busy, bram_sel, row_width, stray_beat, beat_count} !== {1'b1, 2'b00, rw, 1'b0, 12'd0}) begin
         fails++;
         $display("FAIL start: busy=%b sel=%b rw=%0d stray=%b cnt=%0d, expected 1 00 %0d 0 0", busy, bram_sel, row_width, stray_beat, beat_count, rw);
      end
   endtask

   task automatic load_to_run(input logic [31:0] rw, input bit sk, input int na, input int nb, input int ni);
      do_start(rw, sk);
      send_packet(na, 1, 2'b00);
      if (!sk) send_packet(nb, 1, 2'b01);
      send_packet(ni, 1, 2'b10);
      tests++;
      if ({bram_sel, busy, pe_start, beat_count} !== {2'b10, 1'b1, 1'b0, 12'd0}) begin
         fails++;
         $display("FAIL flush: sel=%b busy=%b pe_start=%b cnt=%0d, expected 10 1 0 0", bram_sel, busy, pe_start, beat_count);
      end
      tick();
      tests++;
      if ({bram_sel, busy, pe_start} !== {2'b11, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL run_entry: sel=%b busy=%b pe_start=%b, expected 11 1 1", bram_sel, busy, pe_start);
      end
   endtask

   task automatic finish_run();
      pe_done = 1;
      tick();
      pe_done = 0;
      tests++;
      if ({seq_done, busy, bram_sel, error} !== {1'b1, 1'b0, 2'b11, 1'b0}) begin
         fails++;
         $display("FAIL seq_done: done=%b busy=%b sel=%b err=%b, expected 1 0 11 0", seq_done, busy, bram_sel, error);
      end
      tick();
      tests++;
      if (seq_done !== 1'b0) begin
         fails++;
         $display("FAIL seq_done_pulse: done=%b, expected 0", seq_done);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;
      tests++;
      if ({bram_sel, row_width, pe_start, seq_done, busy, error, err_code, stray_beat, beat_count} !== {2'b11, 32'd0, 6'd0, 1'b0, 12'd0}) begin
         fails++;
         $display("FAIL reset: sel=%b rw=%0d ps=%b sd=%b busy=%b err=%b code=%b stray=%b cnt=%0d, expected all reset values",
                  bram_sel, row_width, pe_start, seq_done, busy, error, err_code, stray_beat, beat_count);
      end
   endtask

   task automatic test_sequence(input logic [31:0] rw, input bit sk, input int na, input int nb, input int ni);
      load_to_run(rw, sk, na, nb, ni);
      tick();
      tests++;
      if ({pe_start, busy} !== 2'b01) begin
         fails++;
         $display("FAIL pe_start_pulse: pe_start=%b busy=%b, expected 0 1", pe_start, busy);
      end
      repeat ($urandom_range(0, 10)) tick();
      finish_run();
   endtask

   task automatic test_overflow();
      do_start(32'd64, 0);
      send_packet(1024, 1, 2'b00);
      tests++;
      if ({bram_sel, error, busy} !== {2'b01, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL limit_legal: sel=%b err=%b busy=%b, expected 01 0 1", bram_sel, error, busy);
      end
      abort = 1;
      tick();
      abort = 0;
      do_start(32'd65, 0);
      send_packet(1025, 0, 2'b00);
      tests++;
      if ({error, err_code, bram_sel, busy} !== {1'b1, 2'b01, 2'b11, 1'b1}) begin
         fails++;
         $display("FAIL overflow_a: err=%b code=%b sel=%b busy=%b, expected 1 01 11 1", error, err_code, bram_sel, busy);
      end
      start = 1;
      tick();
      start = 0;
      tests++;
      if ({error, err_code} !== {1'b1, 2'b01}) begin
         fails++;
         $display("FAIL err_start_ignored: err=%b code=%b, expected 1 01", error, err_code);
      end
      err_clr = 1;
      tick();
      err_clr = 0;
      tests++;
      if ({error, err_code, busy, bram_sel} !== {1'b0, 2'b00, 1'b0, 2'b11}) begin
         fails++;
         $display("FAIL err_clr: err=%b code=%b busy=%b sel=%b, expected 0 00 0 11", error, err_code, busy, bram_sel);
      end
      do_start(32'd66, 1);
      send_packet(1, 1, 2'b00);
      send_packet(2049, 0, 2'b10);
      tests++;
      if ({error, err_code, bram_sel} !== {1'b1, 2'b01, 2'b11}) begin
         fails++;
         $display("FAIL overflow_i: err=%b code=%b sel=%b, expected 1 01 11", error, err_code, bram_sel);
      end
      err_clr = 1;
      tick();
      err_clr = 0;
   endtask

   task automatic test_watchdog();
      int n = 0;
      load_to_run(32'd7, 0, 3, 2, 1);
      while (!error && n < 40) begin
         tick();
         n++;
      end
      tests++;
      if (n !== 15 || err_code !== 2'b10 || bram_sel !== 2'b11) begin
         fails++;
         $display("FAIL watchdog: cycles=%0d code=%b sel=%b, expected 15 10 11", n, err_code, bram_sel);
      end
      abort = 1;
      tick();
      abort = 0;
      tests++;
      if ({busy, error, err_code} !== {1'b0, 1'b0, 2'b10}) begin
         fails++;
         $display("FAIL abort_keeps_code: busy=%b err=%b code=%b, expected 0 0 10", busy, error, err_code);
      end
      err_clr = 1;
      tick();
      err_clr = 0;
      tests++;
      if (err_code !== 2'b00) begin
         fails++;
         $display("FAIL code_clear: code=%b, expected 00", err_code);
      end
      load_to_run(32'd9, 1, 2, 0, 2);
      repeat (14) tick();
      finish_run();
   endtask

   task automatic test_abort();
      cfg_rw = 32'hdead;
      start = 1;
      abort = 1;
      tick();
      start = 0;
      abort = 0;
      tests++;
      if ({busy, bram_sel, beat_count, row_width} !== {1'b0, 2'b11, 12'd0, last_rw}) begin
         fails++;
         $display("FAIL abort_start: busy=%b sel=%b cnt=%0d rw=%0d, expected 0 11 0 %0d", busy, bram_sel, beat_count, row_width, last_rw);
      end
      do_start($urandom, 0);
      send_packet($urandom_range(1, 20), 1, 2'b00);
      send_packet(6, 0, 2'b01);
      valid = 1;
      abort = 1;
      tick();
      valid = 0;
      abort = 0;
      tests++;
      if ({busy, bram_sel, beat_count, error} !== {1'b0, 2'b11, 12'd0, 1'b0}) begin
         fails++;
         $display("FAIL abort_load_b: busy=%b sel=%b cnt=%0d err=%b, expected 0 11 0 0", busy, bram_sel, beat_count, error);
      end
      load_to_run(32'd12, 0, 2, 2, 2);
      cfg_rw = 32'd99;
      start = 1;
      tick();
      start = 0;
      tests++;
      if ({busy, bram_sel, row_width, pe_start} !== {1'b1, 2'b11, 32'd12, 1'b0}) begin
         fails++;
         $display("FAIL start_in_run: busy=%b sel=%b rw=%0d ps=%b, expected 1 11 12 0", busy, bram_sel, row_width, pe_start);
      end
      finish_run();
   endtask

   task automatic test_stray_and_reset();
      valid = 1;
      tick();
      valid = 0;
      repeat (3) tick();
      tests++;
      if ({stray_beat, busy} !== 2'b10) begin
         fails++;
         $display("FAIL stray_set: stray=%b busy=%b, expected 1 0", stray_beat, busy);
      end
      do_start(32'd21, 1);
      send_packet(3, 1, 2'b00);
      send_packet(5, 0, 2'b10);
      valid = 1;
      rst = 1;
      tick();
      rst = 0;
      valid = 0;
      tests++;
      if ({bram_sel, row_width, pe_start, seq_done, busy, error, err_code, stray_beat, beat_count} !== {2'b11, 32'd0, 6'd0, 1'b0, 12'd0}) begin
         fails++;
         $display("FAIL reset_mid: sel=%b rw=%0d busy=%b stray=%b cnt=%0d, expected reset values", bram_sel, row_width, busy, stray_beat, beat_count);
      end
   endtask

   initial begin
      test_reset();
      test_sequence(32'd8, 0, 16, 16, 4);
      test_sequence(32'd5, 1, 4, 0, 2);
      for (int k = 0; k < 6; k++)
         test_sequence($urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40));
      test_overflow();
      test_watchdog();
      test_abort();
      test_stray_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
